// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the execute stage: datapath widths,
// opcode encoding and FSM state encoding.
package ex_stage_pkg;

    localparam int D_BITS_DEF  = 8;
    localparam int ER_BITS_DEF = D_BITS_DEF + 4;

    // Opcodes 10..15 are undefined and reported as illegal.
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MOV = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/ex_stage_if.sv
// Decode -> execute handshake plus the execute-result bundle and status flags.
// er_out layout: [ER_BITS-1:4] value, [3:1] dest, [0] we.
interface ex_stage_if #(
    parameter int D_BITS  = 8,
    parameter int ER_BITS = D_BITS + 4
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_op;
    logic [2:0]         in_dest;
    logic [D_BITS-1:0]  in_a;
    logic [D_BITS-1:0]  in_b;
    logic               flush;
    logic [ER_BITS-1:0] er_out;
    logic               busy;
    logic               illegal;

    modport master (
        output in_valid, in_op, in_dest, in_a, in_b, flush,
        input  in_ready, er_out, busy, illegal
    );

    modport slave (
        input  in_valid, in_op, in_dest, in_a, in_b, flush,
        output in_ready, er_out, busy, illegal
    );
endinterface

// File: rtl/ex_mul.sv
// Iterative shift-add multiplier. One partial product per step; the last
// step (counter == D_BITS-1) presents the low D_BITS of the product on
// o_product together with o_done, so the caller can register it that edge.
module ex_mul #(
    parameter int D_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_clear,
    input  logic [D_BITS-1:0] i_a,
    input  logic [D_BITS-1:0] i_b,
    output logic              o_done,
    output logic [D_BITS-1:0] o_product
);
    localparam int CW = (D_BITS > 1) ? $clog2(D_BITS) : 1;

    logic [D_BITS-1:0] r_a;
    logic [D_BITS-1:0] r_b;
    logic [D_BITS-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic [D_BITS-1:0] w_acc_next;

    // Accumulate the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        w_acc_next = r_acc;
        if (r_b[0]) begin
            w_acc_next = r_acc + r_a;
        end
    end

    assign o_done    = i_step && (r_cnt == CW'(D_BITS - 1));
    assign o_product = w_acc_next;

    // Operand latch on start, one shift-add step per enabled edge; clear aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative multiplier, producing the
// registered {value, dest, we} bundle consumed by writeback.
//
// state | meaning
// IDLE  | ready for a new instruction; ALU ops complete on the accept edge
// MUL   | multiplier stepping; upstream stalled until the product is written
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int D_BITS  = D_BITS_DEF,
    parameter int ER_BITS = D_BITS + 4
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    localparam int SH_BITS = (D_BITS > 1) ? $clog2(D_BITS) : 1;

    state_e             r_state;
    state_e             w_state_next;
    logic [ER_BITS-1:0] r_er;
    logic [ER_BITS-1:0] w_er_next;
    logic               r_illegal;
    logic               w_ill_next;
    logic [2:0]         r_mul_dest;
    logic [D_BITS-1:0]  w_alu_val;
    logic [SH_BITS-1:0] w_shamt;
    logic               w_op_legal;
    logic               w_mul_start;
    logic               w_mul_step;
    logic               w_mul_clear;
    logic               w_mul_done;
    logic [D_BITS-1:0]  w_mul_product;

    assign bus.in_ready = (r_state == ST_IDLE);
    assign bus.busy     = (r_state == ST_MUL);
    assign bus.er_out   = r_er;
    assign bus.illegal  = r_illegal;

    assign w_shamt    = bus.in_b[SH_BITS-1:0];
    assign w_op_legal = (bus.in_op <= OP_MUL);

    // Single-cycle ALU result for the presented opcode.
    always_comb begin
        w_alu_val = '0;
        case (bus.in_op)
            OP_ADD:  w_alu_val = bus.in_a + bus.in_b;
            OP_SUB:  w_alu_val = bus.in_a - bus.in_b;
            OP_AND:  w_alu_val = bus.in_a & bus.in_b;
            OP_OR:   w_alu_val = bus.in_a | bus.in_b;
            OP_XOR:  w_alu_val = bus.in_a ^ bus.in_b;
            OP_SHL:  w_alu_val = bus.in_a << w_shamt;
            OP_SHR:  w_alu_val = bus.in_a >> w_shamt;
            OP_MOV:  w_alu_val = bus.in_b;
            default: w_alu_val = '0;
        endcase
    end

    // Next state and next result bundle; anything other than a write is a bubble.
    always_comb begin
        w_state_next = r_state;
        w_er_next    = '0;
        w_ill_next   = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;
        w_mul_clear  = 1'b0;
        if (bus.flush) begin
            w_state_next = ST_IDLE;
            w_mul_clear  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_op == OP_MUL) begin
                            w_mul_start  = 1'b1;
                            w_state_next = ST_MUL;
                        end else if (w_op_legal) begin
                            if (bus.in_op != OP_NOP) begin
                                w_er_next = {w_alu_val, bus.in_dest, 1'b1};
                            end
                        end else begin
                            w_ill_next = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    w_mul_step = 1'b1;
                    if (w_mul_done) begin
                        w_er_next    = {w_mul_product, r_mul_dest, 1'b1};
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State, result bundle and illegal pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_er      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_er      <= w_er_next;
            r_illegal <= w_ill_next;
        end
    end

    // Destination of the in-flight multiply, captured with its operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_dest <= '0;
        end else if (w_mul_clear) begin
            r_mul_dest <= '0;
        end else if (w_mul_start) begin
            r_mul_dest <= bus.in_dest;
        end
    end

    ex_mul #(
        .D_BITS(D_BITS)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_step    (w_mul_step),
        .i_clear   (w_mul_clear),
        .i_a       (bus.in_a),
        .i_b       (bus.in_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage (D_BITS=8, ER_BITS=12).
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if #(.D_BITS(8), .ER_BITS(12)) bus ();

    ex_stage #(.D_BITS(8), .ER_BITS(12)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       valid;
        logic [3:0] op;
        logic [2:0] dest;
        logic [7:0] a;
        logic [7:0] b;
        logic [11:0] exp_er;
        logic        exp_ill;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] sb_q[$];
    vec_t        vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_er(input logic [11:0] v);
        sb_q.push_back(v);
    endtask

    task automatic check_er(input string name);
        logic [11:0] e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", name, bus.er_out);
        end else begin
            e = sb_q.pop_front();
            check(name, 32'(bus.er_out), 32'(e));
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] dest,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_dest  = dest;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_low;
        int busy_cnt;
        int lat;
        logic seen;

        vecs[0]  = '{1'b1, OP_ADD, 3'd5, 8'd200, 8'd100, 12'h2CB, 1'b0};
        vecs[1]  = '{1'b1, OP_SUB, 3'd1, 8'd3,   8'd5,   12'hFE3, 1'b0};
        vecs[2]  = '{1'b0, OP_ADD, 3'd1, 8'd3,   8'd5,   12'h000, 1'b0};
        vecs[3]  = '{1'b1, OP_SHL, 3'd0, 8'h81,  8'd9,   12'h021, 1'b0};
        vecs[4]  = '{1'b1, OP_SHR, 3'd0, 8'h80,  8'd7,   12'h011, 1'b0};
        vecs[5]  = '{1'b1, OP_MOV, 3'd7, 8'h00,  8'h5A,  12'h5AF, 1'b0};
        vecs[6]  = '{1'b1, 4'd12,  3'd3, 8'h11,  8'h22,  12'h000, 1'b1};
        vecs[7]  = '{1'b0, OP_NOP, 3'd0, 8'h00,  8'h00,  12'h000, 1'b0};
        vecs[8]  = '{1'b1, OP_NOP, 3'd6, 8'h12,  8'h34,  12'h000, 1'b0};
        vecs[9]  = '{1'b1, OP_AND, 3'd3, 8'hF0,  8'h3C,  12'h307, 1'b0};
        vecs[10] = '{1'b1, OP_OR,  3'd4, 8'hF0,  8'h0C,  12'hFC9, 1'b0};
        vecs[11] = '{1'b1, OP_XOR, 3'd6, 8'hFF,  8'h0F,  12'hF0D, 1'b0};
        vecs[12] = '{1'b1, 4'd15,  3'd7, 8'hFF,  8'hFF,  12'h000, 1'b1};
        vecs[13] = '{1'b1, 4'd10,  3'd2, 8'h01,  8'h01,  12'h000, 1'b1};
        vecs[14] = '{1'b1, OP_SHL, 3'd2, 8'h01,  8'd7,   12'h805, 1'b0};
        vecs[15] = '{1'b0, OP_NOP, 3'd0, 8'h00,  8'h00,  12'h000, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_dest  = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.flush    = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_er_out", 32'(bus.er_out), 32'h000);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a multiply
        drive(1'b1, OP_MUL, 3'd2, 8'd13, 8'd11);
        tick();
        drive(1'b0, OP_NOP, 3'd0, 8'd0, 8'd0);
        tick();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midmul_rst_er_out", 32'(bus.er_out), 32'h000);
        check("midmul_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midmul_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.er_out !== 12'h000) seen = 1'b1;
        end
        check("midmul_rst_no_product", 32'(seen), 32'd0);
        drive(1'b1, OP_ADD, 3'd5, 8'd200, 8'd100);
        expect_er(12'h2CB);
        tick();
        check_er("post_rst_add");

        // table-driven single-cycle ops
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].dest, vecs[i].a, vecs[i].b);
            expect_er(vecs[i].exp_er);
            tick();
            check_er($sformatf("vec%0d_er_out", i));
            check($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].exp_ill));
        end

        // MUL 13*11 with a held ADD behind it; operands change after accept
        drive(1'b1, OP_MUL, 3'd2, 8'd13, 8'd11);
        tick();
        ready_low = 0;
        busy_cnt  = 0;
        expect_er(12'h000);
        check_er("mul_n_er_out");
        if (!bus.in_ready) ready_low++;
        if (bus.busy) busy_cnt++;
        drive(1'b1, OP_ADD, 3'd5, 8'd200, 8'd100);
        for (int k = 1; k < 8; k++) begin
            expect_er(12'h000);
            tick();
            check_er($sformatf("mul_bubble%0d", k));
            if (!bus.in_ready) ready_low++;
            if (bus.busy) busy_cnt++;
        end
        expect_er(12'h8F5);
        tick();
        check_er("mul_13x11_result");
        check("mul_done_in_ready", 32'(bus.in_ready), 32'd1);
        check("mul_done_busy", 32'(bus.busy), 32'd0);
        check("mul_ready_low_cycles", 32'(ready_low), 32'd8);
        check("mul_busy_cycles", 32'(busy_cnt), 32'd8);
        expect_er(12'h2CB);
        tick();
        check_er("held_add_after_mul");

        // MUL 20*20 overflow, latency measured with a bound
        drive(1'b1, OP_MUL, 3'd0, 8'd20, 8'd20);
        tick();
        drive(1'b0, OP_NOP, 3'd0, 8'd0, 8'd0);
        lat = 0;
        while (bus.er_out[0] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("mul_20x20_latency", 32'(lat), 32'd8);
        check("mul_20x20_result", 32'(bus.er_out), 32'h901);
        tick();
        check("mul_20x20_then_bubble", 32'(bus.er_out), 32'h000);

        // flush at N+4 of a multiply
        drive(1'b1, OP_MUL, 3'd2, 8'd13, 8'd11);
        tick();
        drive(1'b0, OP_NOP, 3'd0, 8'd0, 8'd0);
        tick();
        tick();
        tick();
        @(negedge clk);
        bus.flush = 1'b1;
        tick();
        check("flush_er_out", 32'(bus.er_out), 32'h000);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.er_out !== 12'h000) seen = 1'b1;
        end
        check("flush_no_product", 32'(seen), 32'd0);

        // flush coincident with a valid ADD
        drive(1'b1, OP_ADD, 3'd5, 8'd200, 8'd100);
        bus.flush = 1'b1;
        tick();
        check("flush_add_discarded", 32'(bus.er_out), 32'h000);
        drive(1'b0, OP_NOP, 3'd0, 8'd0, 8'd0);
        bus.flush = 1'b0;
        tick();
        check("flush_add_never_written", 32'(bus.er_out), 32'h000);
        drive(1'b1, OP_SUB, 3'd1, 8'd3, 8'd5);
        expect_er(12'hFE3);
        tick();
        check_er("sub_after_flush");
        drive(1'b0, OP_NOP, 3'd0, 8'd0, 8'd0);
        tick();
        check("final_bubble", 32'(bus.er_out), 32'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the Harvard pipeline; sits directly upstream of the writeback stage.
- Accepts one decoded instruction (opcode, destination register, two operands) per handshake.
- Computes the result with a single-cycle ALU or an iterative multiplier.
- Drives the registered execute-result bundle {value, dest, we} that writeback consumes.

Parameters:
- D_BITS, 8, datapath width in bits; must match the global `D_BITS` macro.
- ER_BITS, D_BITS+4, execute-result bundle width; must match the global `ER_BITS` macro.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; combinational, equals (state==IDLE).
- in_op  in  4  opcode.
- in_dest  in  3  destination register index.
- in_a  in  D_BITS  operand A.
- in_b  in  D_BITS  operand B.
- flush  in  1  synchronous pipeline flush.
- er_out  out  ER_BITS  result bundle: [ER_BITS-1:4] value, [3:1] dest, [0] we.
- busy  out  1  multiplier in progress (state==MUL).
- illegal  out  1  one-cycle registered pulse when an undefined opcode is accepted.

Behaviour:
- Reset (async, rst=1): er_out=0, illegal=0, state=IDLE, step counter=0, multiplier registers=0. Reset asserted mid-multiply abandons it; no result is ever written.
- Accept occurs on a rising edge with in_valid & in_ready & !flush.
- Opcodes (all arithmetic is modulo 2^D_BITS, unsigned):
  - 0 NOP: we=0.
  - 1 ADD: a+b.
  - 2 SUB: a-b.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL: a << b[log2(D_BITS)-1:0].
  - 7 SHR: logical a >> b[log2(D_BITS)-1:0].
  - 8 MOV: value=b.
  - 9 MUL: low D_BITS of a*b.
  - 10-15: treated as NOP (we=0) and illegal=1 for one cycle.
- Single-cycle ops: accepted at edge N; er_out={result, in_dest, 1} visible after edge N.
- Bubble: any edge without an accept (and not completing a MUL) writes er_out=0, so we=0. er_out never holds a stale we=1 for more than one cycle.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on accepting op 9. Operands and dest are latched, counter=0, er_out=0 at edge N.
  - MUL: one shift-add step per edge, counter increments.
  - On the edge where counter==D_BITS-1 (edge N+D_BITS): er_out={product, dest, 1}, state -> IDLE.
  - in_ready=0 and busy=1 during cycles N+1..N+D_BITS; accept is possible again at edge N+D_BITS+1.
  - MUL latency is D_BITS edges after the accept edge; all intermediate er_out are bubbles.
- flush=1 at an edge (highest priority after reset):
  - state -> IDLE, er_out=0, illegal=0, counter=0.
  - Any presented instruction is discarded even if in_valid=1.
  - An in-flight MUL is aborted.
- in_valid while in_ready=0: ignored. Upstream must hold the instruction; no internal buffering.
- Operands are sampled only at accept; later changes on in_a/in_b do not affect an in-flight MUL.

Decomposition:
- Shared header macros.vh holds `D_BITS`, `ER_BITS`, opcode constants (OP_NOP..OP_MUL), and the er_out field positions (ER_WE=0, ER_DEST=3:1, ER_VAL=ER_BITS-1:4).
- The same header is used by writeback and decode.
- One sub-module: ex_mul, the iterative shift-add multiplier with start/done and a D_BITS-step counter. ex_stage owns the FSM, ALU mux and er_out register.

Test Plan:
All scenarios use D_BITS=8, ER_BITS=12.
1. Reset mid-MUL, then ADD:
   - Accept MUL 13*11, assert rst after 3 cycles -> er_out=0x000 immediately, in_ready=1, no product ever appears.
   - Release rst, ADD 200+100 dest=5 -> er_out=0x2CB one edge later.
2. Back-to-back single-cycle ops:
   - ADD 200+100 dest=5 -> er_out=0x2CB after the accept edge.
   - SUB 3-5 dest=1 on the next edge -> 0xFE3.
   - Idle cycle -> 0x000.
3. MUL and stall:
   - MUL 13*11 dest=2 accepted at edge N -> er_out=0x000 through edge N+7; er_out=0x8F5 after edge N+8.
   - in_ready=0 and busy=1 for exactly 8 cycles.
   - Held ADD accepted at edge N+9.
   - MUL 20*20 -> value 0x90 (overflow truncated).
4. Shifts: SHL a=0x81 b=9 -> value 0x02 (shift amount 1); SHR a=0x80 b=7 -> 0x01; MOV b=0x5A dest=7 -> 0x5AF.
5. Flush: flush at cycle N+4 of a MUL -> er_out=0x000, busy=0, in_ready=1 next cycle, product never written. flush coincident with a valid ADD -> ADD discarded, er_out=0.
6. Illegal opcode: op=12 accepted -> er_out=0x000, illegal=1 for exactly one cycle. NOP -> we=0, illegal=0.
